// File: rtl/display_pkg.sv
// Shared definitions for the four-digit display path: converter FSM states,
// BCD digit width, the blank-digit code and the default conversion range.
package display_pkg;

  // Conversion FSM states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_VAL_DEFAULT = 9999;

  localparam int BCD_W = 4;

  // Digit code the downstream segment decoder renders as all segments off
  localparam logic [BCD_W-1:0] BCD_BLANK = 4'hF;

endpackage

// File: rtl/bcd_adj3.sv
// Double-dabble nibble correction: add 3 to any BCD nibble of 5 or more so the
// following left shift carries correctly into the next decimal digit.
module bcd_adj3
  import display_pkg::*;
(
  input  logic [BCD_W-1:0] nib_in,
  output logic [BCD_W-1:0] nib_out
);

  // Pure combinational add-3 correction
  always_comb begin
    nib_out = (nib_in >= BCD_W'(5)) ? nib_in + BCD_W'(3) : nib_in;
  end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3, one bit per cycle).
// A conversion occupies 16 cycles: the accepting IDLE cycle, IN_W SHIFT cycles
// and one DONE cycle, during which out_valid is high. Digits and ovf are loaded
// on the edge entering DONE and hold until the next conversion completes.
// Build option: define BIN2BCD_CLAMP_EN to show 9999 for out-of-range values;
// otherwise out-of-range values show blank digits (4'hF). ovf is set either way.
module bin2bcd_seq
  import display_pkg::*;
#(
  parameter int IN_W    = 14,
  parameter int MAX_VAL = MAX_VAL_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [IN_W-1:0] value,
  output logic            out_valid,
  output logic            ovf,
  output logic [3:0]      thousands,
  output logic [3:0]      hundreds,
  output logic [3:0]      tens,
  output logic [3:0]      ones
);

  localparam int SCR_W = 4 * BCD_W;
  localparam int CNT_W = $clog2(IN_W);
  localparam logic [IN_W-1:0] MAX_VAL_W = IN_W'(MAX_VAL);

`ifdef BIN2BCD_CLAMP_EN
  localparam logic [BCD_W-1:0] SUB_NIB = BCD_W'(9);
`else
  localparam logic [BCD_W-1:0] SUB_NIB = BCD_BLANK;
`endif
  localparam logic [SCR_W-1:0] SUB_DIGITS = {4{SUB_NIB}};

  state_t            state_q,   state_d;
  logic [CNT_W-1:0]  cnt_q,     cnt_d;
  logic [IN_W-1:0]   shift_q,   shift_d;
  logic [SCR_W-1:0]  scratch_q, scratch_d;
  logic              range_q,   range_d;
  logic [SCR_W-1:0]  digits_q,  digits_d;
  logic              ovf_q,     ovf_d;

  logic [SCR_W-1:0]      scratch_adj;
  logic [SCR_W+IN_W-1:0] shifted;

  // Add-3 correction on every scratch nibble ahead of the shift
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      bcd_adj3 u_adj (
        .nib_in  (scratch_q[gi*BCD_W +: BCD_W]),
        .nib_out (scratch_adj[gi*BCD_W +: BCD_W])
      );
    end
  endgenerate

  assign shifted = {scratch_adj, shift_q} << 1;

  // Next-state, datapath and output-register load decisions
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    scratch_d = scratch_q;
    range_d   = range_q;
    digits_d  = digits_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d   = SHIFT;
          shift_d   = value;
          scratch_d = '0;
          cnt_d     = CNT_W'(IN_W - 1);
          range_d   = (value > MAX_VAL_W);
        end
      end
      SHIFT: begin
        scratch_d = shifted[SCR_W+IN_W-1:IN_W];
        shift_d   = shifted[IN_W-1:0];
        cnt_d     = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          // Last shift: publish the finished digits on the edge entering DONE
          state_d  = DONE;
          cnt_d    = '0;
          digits_d = range_q ? SUB_DIGITS : shifted[SCR_W+IN_W-1:IN_W];
          ovf_d    = range_q;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      shift_q   <= '0;
      scratch_q <= '0;
      range_q   <= 1'b0;
      digits_q  <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      scratch_q <= scratch_d;
      range_q   <= range_d;
      digits_q  <= digits_d;
      ovf_q     <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign ovf       = ovf_q;
  assign thousands = digits_q[15:12];
  assign hundreds  = digits_q[11:8];
  assign tens      = digits_q[7:4];
  assign ones      = digits_q[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: reset/idle, table of boundary values,
// random values against a decimal-arithmetic reference, back-to-back with a
// busy input, and reset in the middle of a conversion.
// Honours BIN2BCD_CLAMP_EN the same way as the design build.
module tb_bin2bcd_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] value;
  logic        out_valid;
  logic        ovf;
  logic [3:0]  thousands, hundreds, tens, ones;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

`ifdef BIN2BCD_CLAMP_EN
  localparam logic [3:0] SUB = 4'd9;
`else
  localparam logic [3:0] SUB = 4'hF;
`endif

  bin2bcd_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .value     (value),
    .out_valid (out_valid),
    .ovf       (ovf),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [13:0] v;
    logic [3:0]  th, hu, te, on;
    logic        ov;
  } vec_t;

  // Reference: {ovf, thousands, hundreds, tens, ones} from plain decimal arithmetic
  function automatic logic [16:0] ref_model(input int v);
    if (v > 9999) return {1'b1, SUB, SUB, SUB, SUB};
    return {1'b0, 4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [16:0] outs();
    return {ovf, thousands, hundreds, tens, ones};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Present v, wait for acceptance, then count edges until out_valid.
  task automatic convert(input logic [13:0] v, output logic [16:0] res, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1;
    value    = v;
    n = 0;
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    value    = 14'($urandom);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = outs();
  endtask

  initial begin
    vec_t        vecs[10];
    logic [16:0] res;
    int          lat;
    int          strobes;
    int          t0, t1;
    logic [16:0] r0, r1;
    logic [13:0] rv;

    vecs[0] = '{14'd0,     4'd0, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[1] = '{14'd9,     4'd0, 4'd0, 4'd0, 4'd9, 1'b0};
    vecs[2] = '{14'd10,    4'd0, 4'd0, 4'd1, 4'd0, 1'b0};
    vecs[3] = '{14'd999,   4'd0, 4'd9, 4'd9, 4'd9, 1'b0};
    vecs[4] = '{14'd1000,  4'd1, 4'd0, 4'd0, 4'd0, 1'b0};
    vecs[5] = '{14'd9999,  4'd9, 4'd9, 4'd9, 4'd9, 1'b0};
    vecs[6] = '{14'd1234,  4'd1, 4'd2, 4'd3, 4'd4, 1'b0};
    vecs[7] = '{14'd10000, SUB,  SUB,  SUB,  SUB,  1'b1};
    vecs[8] = '{14'd16383, SUB,  SUB,  SUB,  SUB,  1'b1};
    vecs[9] = '{14'd5678,  4'd5, 4'd6, 4'd7, 4'd8, 1'b0};

    // Reset state, checked while reset is still asserted
    rst_n = 1'b0; in_valid = 1'b0; value = '0;
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_outputs", 32'(outs()), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle for 50 cycles: no strobe
    strobes = 0;
    repeat (50) begin
      @(negedge clk);
      if (out_valid) strobes++;
    end
    chk("idle_no_strobe", 32'(strobes), 32'd0);
    chk("idle_outputs", 32'(outs()), 32'd0);

    // Table: boundaries and out-of-range
    for (int i = 0; i < 10; i++) begin
      convert(vecs[i].v, res, lat);
      chk($sformatf("table_%0d", vecs[i].v), 32'(res),
          32'({vecs[i].ov, vecs[i].th, vecs[i].hu, vecs[i].te, vecs[i].on}));
      $display("vector value=%0d digits=%h ovf=%0b lat=%0d", vecs[i].v, res[15:0], res[16], lat);
    end

    // Single conversion detail: latency, one-cycle strobe, digits hold
    convert(14'd1234, res, lat);
    chk("lat_1234", 32'(lat), 32'd14);
    chk("digits_1234", 32'(res), 32'(ref_model(1234)));
    @(posedge clk); #1;
    chk("strobe_one_cycle", 32'(out_valid), 32'd0);
    chk("ready_after_done", 32'(in_ready), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    chk("digits_hold", 32'(outs()), 32'(ref_model(1234)));

    // Back-to-back with busy input: 42 held, switched to 7 after acceptance
    @(negedge clk);
    in_valid = 1'b1; value = 14'd42;
    @(posedge clk); #1;
    value = 14'd7;
    strobes = 0; t0 = 0; t1 = 0; r0 = '0; r1 = '0;
    for (int k = 0; k < 60 && strobes < 2; k++) begin
      if (!in_ready && out_valid == 1'b0) value = 14'($urandom);
      if (out_valid) begin
        if (strobes == 0) begin t0 = cyc; r0 = outs(); value = 14'd7; end
        else begin t1 = cyc; r1 = outs(); end
        strobes++;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("b2b_strobes", 32'(strobes), 32'd2);
    chk("b2b_first_42", 32'(r0), 32'(ref_model(42)));
    chk("b2b_second_7", 32'(r1), 32'(ref_model(7)));
    chk("b2b_spacing", 32'(t1 - t0), 32'd16);
    $display("back-to-back first=%h second=%h spacing=%0d", r0[15:0], r1[15:0], t1 - t0);

    // Reset mid-conversion
    convert(14'd5678, res, lat);
    @(negedge clk);
    in_valid = 1'b1; value = 14'd5678;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_outputs", 32'({out_valid, outs()}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    strobes = 0;
    repeat (30) begin
      @(negedge clk);
      if (out_valid) strobes++;
    end
    chk("midrst_no_strobe", 32'(strobes), 32'd0);
    convert(14'd5678, res, lat);
    chk("midrst_fresh_5678", 32'(res), 32'(ref_model(5678)));
    $display("reset mid-conversion then 5678 -> %h ovf=%0b", res[15:0], res[16]);

    // Strided sweep of the in-range values
    for (int v = 0; v <= 9999; v += 37) begin
      convert(14'(v), res, lat);
      chk($sformatf("sweep_%0d", v), 32'(res), 32'(ref_model(v)));
    end
    convert(14'd9999, res, lat);
    chk("sweep_9999", 32'(res), 32'(ref_model(9999)));

    // Random values across the full input range
    for (int i = 0; i < 1200; i++) begin
      rv = (i % 4 == 0) ? 14'($urandom_range(10000, 16383)) : 14'($urandom_range(0, 9999));
      convert(rv, res, lat);
      chk($sformatf("rand_%0d", rv), 32'(res), 32'(ref_model(int'(rv))));
      chk("rand_lat", 32'(lat), 32'd14);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
